seq_scan_ctrl: RTL and testbench

Word-level controller for the overlapping "1001" serial detector. It accepts a parallel word over a valid/ready handshake and feeds it to a detector core one bit per cycle, MSB first. It counts detections in the word and returns the count over a second valid/ready handshake. It sits between a parallel producer (bus or FIFO) and the bit-serial detector, so the detector can be used on word-oriented data.

---
 rtl/seq_scan_pkg.sv | 16 +
 rtl/seq1001_core.sv | 39 +++
 rtl/seq_scan_ctrl.sv | 95 +++++++++
 tb/tb_seq_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared encodings and default sizing for the word-level "1001" scan controller.
package seq_scan_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] CORE_S0 = 2'd0;
    localparam logic [1:0] CORE_S1 = 2'd1;
    localparam logic [1:0] CORE_S2 = 2'd2;
    localparam logic [1:0] CORE_S3 = 2'd3;

endpackage

// File: rtl/seq1001_core.sv
// Bit-serial overlapping "1001" detector; state advances only on en or clr.
module seq1001_core
    import seq_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic din,
    output logic hit
);

    logic [1:0] r_state;
    logic [1:0] w_next;

    always_comb begin
        w_next = CORE_S0;
        case (r_state)
            CORE_S0: w_next = din ? CORE_S1 : CORE_S0;
            CORE_S1: w_next = din ? CORE_S1 : CORE_S2;
            CORE_S2: w_next = din ? CORE_S1 : CORE_S3;
            CORE_S3: w_next = din ? CORE_S1 : CORE_S0;
            default: w_next = CORE_S0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CORE_S0;
        end else if (clr) begin
            r_state <= CORE_S0;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    assign hit = en & (r_state == CORE_S3) & din;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-level controller: accepts a word, streams it MSB-first into the
// detector core, and returns a saturating match count plus last-bit hit flag.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_keep,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last_hit,
    output logic             busy
);

    localparam int BCW = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BCW-1:0]   r_bitcnt;
    logic [CNT_W-1:0] r_count;
    logic             r_last_hit;

    logic w_accept;
    logic w_en;
    logic w_clr;
    logic w_hit;

    assign w_accept = (r_state == ST_IDLE) & in_valid;
    assign w_en     = (r_state == ST_SHIFT);
    // History is only cleared at accept time; keep=1 lets a match span words.
    assign w_clr    = w_accept & ~in_keep;

    seq1001_core u_core (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (w_clr),
        .din (r_shift[WIDTH-1]),
        .hit (w_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_count    <= '0;
            r_last_hit <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_shift    <= in_data;
                        r_bitcnt   <= BCW'(WIDTH - 1);
                        r_count    <= '0;
                        r_last_hit <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    if (w_hit && (r_count != '1)) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (r_bitcnt == '0) begin
                        r_last_hit <= w_hit;
                        r_state    <= ST_DONE;
                    end else begin
                        r_bitcnt <= r_bitcnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_DONE);
    assign busy         = (r_state == ST_SHIFT) | (r_state == ST_DONE);
    assign out_count    = r_count;
    assign out_last_hit = r_last_hit;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: 8-bit default instance plus a 16-bit/2-bit-count instance.
module tb_seq_scan_ctrl;

    logic clk;
    logic rst;

    logic       a_in_valid, a_in_ready, a_in_keep;
    logic [7:0] a_in_data;
    logic       a_out_valid, a_out_ready, a_out_last_hit, a_busy;
    logic [3:0] a_out_count;

    logic        b_in_valid, b_in_ready, b_in_keep;
    logic [15:0] b_in_data;
    logic        b_out_valid, b_out_ready, b_out_last_hit, b_busy;
    logic [1:0]  b_out_count;

    int vectors;
    int miscompares;

    seq_scan_ctrl #(.WIDTH(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_keep(a_in_keep),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
        .out_last_hit(a_out_last_hit), .busy(a_busy)
    );

    seq_scan_ctrl #(.WIDTH(16), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_keep(b_in_keep),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
        .out_last_hit(b_out_last_hit), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer a word to dut_a from a negedge and return once it has been accepted.
    task automatic send_a(input logic [7:0] d, input logic keep);
        int w;
        @(negedge clk);
        w = 0;
        while (!a_in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (!a_in_ready) begin
            miscompares++;
            $display("FAIL accept_wait: in_ready=%b required 1", a_in_ready);
        end
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_keep  = keep;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = 8'hxx;
        a_in_keep  = 1'bx;
    endtask

    // Count edges after accept until out_valid is seen at a negedge.
    task automatic wait_done_a(output int lat);
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (a_out_valid) break;
        end
        vectors++;
        if (!a_out_valid) begin
            miscompares++;
            $display("FAIL done_wait: out_valid=%b required 1 within 30 cycles", a_out_valid);
        end
    endtask

    task automatic ack_a();
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        vectors++;
        if ({a_in_ready, a_out_valid, a_out_count, a_out_last_hit, a_busy} !== 8'b1_0_0000_0_0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b vld=%b cnt=%0d lh=%b busy=%b required 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_out_count, a_out_last_hit, a_busy);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        send_a(8'b1001_0010, 1'b0);
        vectors++;
        if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_shift: busy=%b in_ready=%b required 1 0", a_busy, a_in_ready);
        end
        wait_done_a(lat);
        vectors++;
        if (lat != 8) begin
            miscompares++;
            $display("FAIL latency: got %0d required 8", lat);
        end
        vectors++;
        if (a_out_count !== 4'd2 || a_out_last_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_92: cnt=%0d lh=%b required 2 0", a_out_count, a_out_last_hit);
        end
        ack_a();

        send_a(8'b1001_1001, 1'b0);
        wait_done_a(lat);
        vectors++;
        if (a_out_count !== 4'd2 || a_out_last_hit !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_99: cnt=%0d lh=%b required 2 1", a_out_count, a_out_last_hit);
        end
        ack_a();
    endtask

    task automatic test_keep();
        int lat;
        logic [3:0] exp_cnt [2];
        exp_cnt[0] = 4'd0;
        exp_cnt[1] = 4'd1;
        for (int k = 1; k >= 0; k--) begin
            send_a(8'b0000_0100, 1'b0);
            wait_done_a(lat);
            vectors++;
            if (a_out_count !== 4'd0) begin
                miscompares++;
                $display("FAIL keep_first_word k=%0d: cnt=%0d required 0", k, a_out_count);
            end
            ack_a();
            send_a(8'b1000_0000, k[0]);
            wait_done_a(lat);
            vectors++;
            if (a_out_count !== exp_cnt[k] || a_out_last_hit !== 1'b0) begin
                miscompares++;
                $display("FAIL keep_second_word k=%0d: cnt=%0d lh=%b required %0d 0",
                         k, a_out_count, a_out_last_hit, exp_cnt[k]);
            end
            ack_a();
        end
    endtask

    task automatic test_saturate();
        int lat;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = 16'b1001_0010_0100_1001;
        b_in_keep  = 1'b0;
        vectors++;
        if (b_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_ready: in_ready=%b required 1", b_in_ready);
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (b_out_valid) break;
        end
        vectors++;
        if (lat != 16 || !b_out_valid) begin
            miscompares++;
            $display("FAIL sat_latency: got %0d valid=%b required 16 1", lat, b_out_valid);
        end
        vectors++;
        if (b_out_count !== 2'd3 || b_out_last_hit !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_count: cnt=%0d lh=%b required 3 1", b_out_count, b_out_last_hit);
        end
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int lat;
        send_a(8'b1001_1001, 1'b0);
        wait_done_a(lat);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (a_out_valid !== 1'b1 || a_out_count !== 4'd2 || a_out_last_hit !== 1'b1 || a_in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall c=%0d: vld=%b cnt=%0d lh=%b rdy=%b required 1 2 1 0",
                         c, a_out_valid, a_out_count, a_out_last_hit, a_in_ready);
            end
        end
        ack_a();
        @(negedge clk);
        vectors++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: rdy=%b vld=%b busy=%b required 1 0 0", a_in_ready, a_out_valid, a_busy);
        end
    endtask

    // Bits 0,1,0,0 leave the core in S3; reset must wipe that history.
    task automatic test_mid_reset();
        int lat;
        send_a(8'b0100_1111, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({a_in_ready, a_out_valid, a_out_count, a_out_last_hit, a_busy} !== 8'b1_0_0000_0_0) begin
            miscompares++;
            $display("FAIL midreset_outputs: rdy=%b vld=%b cnt=%0d lh=%b busy=%b required 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_out_count, a_out_last_hit, a_busy);
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (a_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_no_valid: out_valid=%b required 0", a_out_valid);
        end
        rst = 1'b1;
        send_a(8'h90, 1'b1);
        wait_done_a(lat);
        vectors++;
        if (a_out_count !== 4'd1 || a_out_last_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_next_word: cnt=%0d lh=%b required 1 0", a_out_count, a_out_last_hit);
        end
        ack_a();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_keep = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_keep = 1'b0; b_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_keep();
        test_saturate();
        test_stall();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
